// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single synchronous 1024x32 memory port.
// Port 0 is the CPU path, port 1 the loader. Round-robin on ties, optional
// locked bursts, and a starvation breaker that forces the waiting port through
// after MAX_WAIT consecutive denied cycles.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {StRr, StLock0, StLock1} state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;      // last granted port
    logic [CNT_W-1:0] wait_q, wait_d;      // denied cycles of the port waiting on a lock
    logic             rvalid0_q, rvalid1_q;
    logic             held0, held1;
    logic             brk;                 // starvation break this cycle

    // Grant decision: lock holder first (unless the waiter has starved), else round-robin.
    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        brk   = 1'b0;
        held0 = (state_q == StLock0) && req0 && lock0;
        held1 = (state_q == StLock1) && req1 && lock1;
        if (held0) begin
            if (req1 && (wait_q == CNT_W'(MAX_WAIT))) begin
                gnt1 = 1'b1;
                brk  = 1'b1;
            end else begin
                gnt0 = 1'b1;
            end
        end else if (held1) begin
            if (req0 && (wait_q == CNT_W'(MAX_WAIT))) begin
                gnt0 = 1'b1;
                brk  = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else if (req0 && (!req1 || last_q)) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Next state: a locked grant (not a forced break) enters/stays in LOCKn, else RR.
    always_comb begin
        state_d = StRr;
        last_d  = last_q;
        wait_d  = '0;
        if (gnt0 || gnt1) begin
            last_d = gnt1;
        end
        if (gnt0 && lock0 && !brk) begin
            state_d = StLock0;
            if (req1) begin
                // Count continues only while the same port keeps the lock.
                wait_d = (state_q == StLock0) ? wait_q + CNT_W'(1) : CNT_W'(1);
            end
        end else if (gnt1 && lock1 && !brk) begin
            state_d = StLock1;
            if (req0) begin
                wait_d = (state_q == StLock1) ? wait_q + CNT_W'(1) : CNT_W'(1);
            end
        end
    end

    // Memory bus mux: winner drives everything, idle bus is all zero.
    always_comb begin
        mem_we    = 1'b0;
        mem_raddr = '0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = we0;
            mem_raddr = addr0;
            mem_waddr = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_we    = we1;
            mem_raddr = addr1;
            mem_waddr = addr1;
            mem_wdata = wdata1;
        end
    end

    // State registers and read-valid pipeline, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRr;
            last_q    <= 1'b1;
            wait_q    <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            wait_q    <= wait_d;
            rvalid0_q <= gnt0 & ~we0;
            rvalid1_q <= gnt1 & ~we1;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter with a behavioural arbitration model
// and a bench-side 1024x32 synchronous memory.
module tb_mem_port_arbiter;

    localparam int unsigned MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req[2];
    logic        we[2];
    logic        lock[2];
    logic [31:0] addr[2];
    logic [31:0] wdata[2];
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [31:0] rdata, mem_raddr, mem_waddr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req[0]),
        .req1     (req[1]),
        .we0      (we[0]),
        .we1      (we[1]),
        .lock0    (lock[0]),
        .lock1    (lock[1]),
        .addr0    (addr[0]),
        .addr1    (addr[1]),
        .wdata0   (wdata[0]),
        .wdata1   (wdata[1]),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata    (rdata),
        .mem_we   (mem_we),
        .mem_raddr(mem_raddr),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    logic [31:0] mem[1024];      // the memory the arbiter talks to
    logic [31:0] ref_mem[1024];  // model's view of memory contents

    // Reference model: mode -1 = round-robin, 0/1 = that port holds a lock.
    int          m_mode, m_last, m_wait;
    bit          e_rv[2];
    logic [31:0] e_rdata;

    // What the bench saw in the most recent cycle (used to steer stimulus).
    bit          g_seen[2];
    bit          rv_seen[2];
    bit          we_seen;
    logic [31:0] rd_seen;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input int p, input bit r, input bit w, input bit l,
                         input logic [31:0] a, input logic [31:0] d);
        req[p]   = r;
        we[p]    = w;
        lock[p]  = l;
        addr[p]  = a;
        wdata[p] = d;
    endtask

    // One clock cycle: check at negedge, advance the model, clock the memory.
    task automatic cycle();
        int          w;
        bit          b;
        int          o;
        logic        p_we;
        logic [31:0] p_wa, p_ra, p_wd;
        @(negedge clk);
        w = -1;
        b = 1'b0;
        if (!rst) begin
            if (m_mode >= 0 && req[m_mode] && lock[m_mode]) begin
                o = 1 - m_mode;
                if (req[o] && m_wait == MAX_WAIT) begin
                    w = o;
                    b = 1'b1;
                end else begin
                    w = m_mode;
                end
            end else if (req[0] && req[1]) begin
                w = (m_last == 0) ? 1 : 0;
            end else if (req[0]) begin
                w = 0;
            end else if (req[1]) begin
                w = 1;
            end
        end
        check_eq("gnt0", 32'(gnt0), 32'(w == 0));
        check_eq("gnt1", 32'(gnt1), 32'(w == 1));
        check_eq("mem_we", 32'(mem_we), 32'(w >= 0 && we[w >= 0 ? w : 0]));
        check_eq("mem_raddr", mem_raddr, (w >= 0) ? addr[w] : 32'h0);
        check_eq("mem_waddr", mem_waddr, (w >= 0) ? addr[w] : 32'h0);
        check_eq("mem_wdata", mem_wdata, (w >= 0) ? wdata[w] : 32'h0);
        check_eq("rvalid0", 32'(rvalid0), 32'(e_rv[0]));
        check_eq("rvalid1", 32'(rvalid1), 32'(e_rv[1]));
        if (e_rv[0] || e_rv[1]) check_eq("rdata", rdata, e_rdata);

        g_seen[0]  = gnt0;
        g_seen[1]  = gnt1;
        rv_seen[0] = rvalid0;
        rv_seen[1] = rvalid1;
        we_seen    = mem_we;
        rd_seen    = rdata;
        p_we = mem_we;
        p_wa = mem_waddr;
        p_ra = mem_raddr;
        p_wd = mem_wdata;

        e_rv[0] = 1'b0;
        e_rv[1] = 1'b0;
        if (rst) begin
            m_mode = -1;
            m_last = 1;
            m_wait = 0;
        end else if (w >= 0) begin
            if (we[w]) ref_mem[addr[w][9:0]] = wdata[w];
            else begin
                e_rv[w] = 1'b1;
                e_rdata = ref_mem[addr[w][9:0]];
            end
            m_last = w;
            if (lock[w] && !b) begin
                if (req[1 - w]) m_wait = (m_mode == w) ? m_wait + 1 : 1;
                else m_wait = 0;
                m_mode = w;
            end else begin
                m_mode = -1;
                m_wait = 0;
            end
        end else begin
            m_mode = -1;
            m_wait = 0;
        end

        @(posedge clk);
        mem_rdata = mem[p_ra[9:0]];
        if (p_we) mem[p_wa[9:0]] = p_wd;
        #1;
    endtask

    int first_g0, resume, g1_cnt;
    bit idle_bad;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[5]     = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        for (int p = 0; p < 2; p++) drive(p, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        m_mode = -1;
        m_last = 1;
        m_wait = 0;
        e_rv[0] = 1'b0;
        e_rv[1] = 1'b0;
        e_rdata = 32'h0;

        // Reset, then a single port-0 read of addr 5.
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 32'd5, 32'h0);
        cycle();
        check_eq("t1_gnt0", 32'(g_seen[0]), 32'd1);
        req[0] = 1'b0;
        cycle();
        check_eq("t1_rvalid0", 32'(rv_seen[0]), 32'd1);
        check_eq("t1_rdata", rd_seen, 32'hDEADBEEF);

        // Locked loader burst vs held CPU read: breaker fires after MAX_WAIT.
        drive(1, 1'b1, 1'b1, 1'b1, 32'd0, $urandom);
        drive(0, 1'b1, 1'b0, 1'b0, 32'd3, 32'h0);
        first_g0 = -1;
        resume   = -1;
        g1_cnt   = 0;
        for (int c = 0; c < 40 && (req[0] || req[1]); c++) begin
            cycle();
            if (first_g0 >= 0 && c == first_g0 + 1) resume = int'(g_seen[1]);
            if (g_seen[0] && first_g0 < 0) begin
                first_g0 = c;
                req[0]   = 1'b0;
            end
            if (g_seen[1]) begin
                g1_cnt++;
                if (addr[1] == 32'd15) begin
                    req[1]  = 1'b0;
                    lock[1] = 1'b0;
                end else begin
                    addr[1]  = addr[1] + 32'd1;
                    wdata[1] = $urandom;
                end
            end
        end
        check_eq("t3_first_gnt0", 32'(first_g0), 32'd8);
        check_eq("t3_gnt1_resume", 32'(resume), 32'd1);
        check_eq("t3_gnt1_total", 32'(g1_cnt), 32'd16);

        // Both ports held, no lock: strict alternation starting with port 0.
        drive(0, 1'b1, 1'b1, 1'b0, 32'd20, $urandom);
        drive(1, 1'b1, 1'b0, 1'b0, 32'd40, 32'h0);
        for (int c = 0; c < 4; c++) begin
            cycle();
            check_eq("t2_alt_gnt0", 32'(g_seen[0]), 32'((c % 2) == 0));
            for (int p = 0; p < 2; p++)
                if (g_seen[p]) begin
                    addr[p]  = addr[p] + 32'd1;
                    wdata[p] = $urandom;
                end
        end
        req[0] = 1'b0;
        req[1] = 1'b0;

        // Write via port 1, then read the same address via port 0.
        drive(1, 1'b1, 1'b1, 1'b0, 32'd7, 32'h12345678);
        cycle();
        req[1] = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 32'd7, 32'h0);
        cycle();
        req[0] = 1'b0;
        cycle();
        check_eq("t4_rdata", rd_seen, 32'h12345678);
        check_eq("t4_rvalid0", 32'(rv_seen[0]), 32'd1);
        check_eq("t4_rvalid1", 32'(rv_seen[1]), 32'd0);

        // Reset during a port-0 read request; first tie afterwards goes to port 0.
        drive(0, 1'b1, 1'b0, 1'b0, 32'd5, 32'h0);
        rst = 1'b1;
        cycle();
        check_eq("t5_gnt_in_rst", 32'(g_seen[0] | g_seen[1]), 32'd0);
        rst = 1'b0;
        drive(1, 1'b1, 1'b0, 1'b0, 32'd7, 32'h0);
        cycle();
        check_eq("t5_rvalid0", 32'(rv_seen[0]), 32'd0);
        check_eq("t5_tie_gnt0", 32'(g_seen[0]), 32'd1);
        req[0] = 1'b0;
        cycle();
        req[1] = 1'b0;

        // Idle for 10 cycles.
        idle_bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (c > 0) idle_bad |= g_seen[0] | g_seen[1] | we_seen | rv_seen[0] | rv_seen[1];
        end
        check_eq("t6_idle", 32'(idle_bad), 32'd0);

        // Randomised traffic with held requests, bursts and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom % 300) == 0;
            for (int p = 0; p < 2; p++) begin
                if (req[p] && !g_seen[p]) begin
                    if (($urandom % 16) == 0) lock[p] = ~lock[p];
                end else if (req[p] && g_seen[p] && lock[p] && ($urandom % 4) != 0) begin
                    addr[p]  = addr[p] + 32'd1;
                    wdata[p] = $urandom;
                    we[p]    = $urandom;
                end else begin
                    drive(p, ($urandom % 3) != 0, $urandom, ($urandom % 3) == 0,
                          32'($urandom_range(0, 15)) | ((($urandom % 8) == 0) ? 32'h1000 : 32'h0),
                          $urandom);
                end
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
